// File: rtl/mbssoc_mem_master_pkg.sv
// Shared encodings for the SoC word-RAM bus master: access sizes and the alignment rule.
package mbssoc_mem_master_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  // Reserved size 2'b11 is reported through the same error path as a misaligned access.
  function automatic logic mem_access_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      MEM_SIZE_B: err = 1'b0;
      MEM_SIZE_H: err = off[0];
      MEM_SIZE_W: err = |off;
      default:    err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mbssoc_mem_lane.sv
// Little-endian byte-lane steering: merges store data into an old word and extracts
// an extended load value from it. Used by both the load and read-modify-write paths.
module mbssoc_mem_lane
  import mbssoc_mem_master_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_signed,
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);

  logic [15:0] w_shift;

  assign w_shift = 16'(i_old >> {i_off, 3'b000});

  always_comb begin
    o_merged = i_new;
    o_load   = i_old;
    case (i_size)
      MEM_SIZE_B: begin
        o_merged                       = i_old;
        o_merged[{i_off, 3'b000} +: 8] = i_new[7:0];
        o_load                         = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
      end
      MEM_SIZE_H: begin
        o_merged                            = i_old;
        o_merged[{i_off[1], 4'b0000} +: 16] = i_new[15:0];
        o_load                              = {{16{i_signed & w_shift[15]}}, w_shift};
      end
      default: begin
        o_merged = i_new;
        o_load   = i_old;
      end
    endcase
  end

endmodule

// File: rtl/mbssoc_mem_master.sv
// CPU-side bus initiator for the word-only SoC RAM: single outstanding request,
// registered strobes, one-cycle read latency, sub-word stores done as read-modify-write.
module mbssoc_mem_master
  import mbssoc_mem_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_signed,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic                  o_resp_err,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_ram_we,
  output logic                  o_ram_re,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  inout  wire  [DATA_WIDTH-1:0] io_ram_data
);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StRmwAddr,
    StRmwData,
    StWr,
    StResp
  } state_e;

  state_e r_state, w_state_d;

  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [1:0]            r_off;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_wbuf;
  logic                  r_ram_we;
  logic                  r_ram_re;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] r_resp_rdata;

  logic                  w_accept;
  logic                  w_req_err;
  logic                  w_ram_we_d;
  logic                  w_ram_re_d;
  logic                  w_resp_valid_d;
  logic                  w_ram_we_gated;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_load;

  assign o_req_ready = (r_state == StIdle);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_req_err   = mem_access_err(i_req_size, i_req_addr[1:0]);

  mbssoc_mem_lane u_lane (
    .i_size   (r_size),
    .i_off    (r_off),
    .i_signed (r_signed),
    .i_old    (io_ram_data),
    .i_new    (r_wdata),
    .o_merged (w_merged),
    .o_load   (w_load)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_we         <= 1'b0;
      r_size       <= MEM_SIZE_W;
      r_signed     <= 1'b0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_wbuf       <= '0;
      r_ram_we     <= 1'b0;
      r_ram_re     <= 1'b0;
      r_ram_addr   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_state_d;
      r_ram_we     <= w_ram_we_d;
      r_ram_re     <= w_ram_re_d;
      r_resp_valid <= w_resp_valid_d;
      if (w_accept) begin
        r_we     <= i_req_we;
        r_size   <= i_req_size;
        r_signed <= i_req_signed;
        r_off    <= i_req_addr[1:0];
        r_wdata  <= i_req_wdata;
        r_wbuf   <= i_req_wdata;
        if (!w_req_err) r_ram_addr <= i_req_addr;
      end
      if (r_state == StRmwData) r_wbuf <= w_merged;
      // Response fields are only updated when entering RESP, so they hold in between.
      if (w_state_d == StResp) begin
        r_resp_err   <= (r_state == StIdle);
        r_resp_rdata <= (r_state == StRdData) ? w_load : '0;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_req_err)                    w_state_d = StResp;
          else if (!i_req_we)               w_state_d = StRdAddr;
          else if (i_req_size == MEM_SIZE_W) w_state_d = StWr;
          else                              w_state_d = StRmwAddr;
        end
      end
      StRdAddr:  w_state_d = StRdData;
      StRdData:  w_state_d = StResp;
      StRmwAddr: w_state_d = StRmwData;
      StRmwData: w_state_d = StWr;
      StWr:      w_state_d = StResp;
      StResp:    w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_ram_re_d     = (w_state_d == StRdAddr)  || (w_state_d == StRdData) ||
                     (w_state_d == StRmwAddr) || (w_state_d == StRmwData);
    w_ram_we_d     = (w_state_d == StWr);
    w_resp_valid_d = (w_state_d == StResp);
  end

  // Reset gates the write strobe so an abandoned store never lands at the reset edge.
  assign w_ram_we_gated = r_ram_we && !i_rst;
  assign o_ram_we       = w_ram_we_gated;
  assign o_ram_re       = r_ram_re;
  assign o_ram_addr     = r_ram_addr;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_err     = r_resp_err;
  assign o_resp_rdata   = r_resp_rdata;
  assign io_ram_data    = w_ram_we_gated ? r_wbuf : 'z;

endmodule

// File: tb/tb_mbssoc_mem_master.sv
// Scoreboard bench for mbssoc_mem_master with a registered-address word RAM model
// and a per-cycle bus monitor.
module tb_mbssoc_mem_master;
  import mbssoc_mem_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, ram_we, ram_re;
  logic [31:0] resp_rdata, ram_addr;
  wire  [31:0] ram_data;

  always #5 clk = ~clk;

  mbssoc_mem_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_size   (req_size),
    .i_req_signed (req_signed),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_err   (resp_err),
    .o_resp_rdata (resp_rdata),
    .o_ram_we     (ram_we),
    .o_ram_re     (ram_re),
    .o_ram_addr   (ram_addr),
    .io_ram_data  (ram_data)
  );

  // RAM model: address registered while ram_re, data driven while ram_re.
  logic [31:0] mem [16];
  logic [3:0]  raddr_q = '0;

  assign ram_data = ram_re ? mem[raddr_q] : 'z;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[5:2]] <= ram_data;
    if (ram_re) raddr_q <= ram_addr[5:2];
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] addr;
    int          lat;
    int          n_re;
    int          n_we;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   re_cnt  = 0;
  int   we_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      re_cnt = 0;
      we_cnt = 0;
    end else begin
      if (ram_re || ram_we) begin
        check_eq("we_re_overlap", {31'b0, ram_we && ram_re}, 32'd0);
        if (sb.size() == 0) begin
          check_eq("stray_strobe", 32'd1, 32'd0);
        end else begin
          check_eq("ram_addr", ram_addr, sb[0].addr);
          if (ram_we) check_eq("wr_bus", ram_data, sb[0].wdata);
          if (ram_re) check_eq("rd_bus_owner", ram_data, mem[raddr_q]);
        end
        if (ram_re) re_cnt++;
        if (ram_we) we_cnt++;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
          check_eq("resp_rdata", resp_rdata, mon_e.rdata);
          check_eq("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
          check_eq("re_cycles", 32'(re_cnt), 32'(mon_e.n_re));
          check_eq("we_cycles", 32'(we_cnt), 32'(mon_e.n_we));
        end
        re_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic [31:0] exp_wdata);
    exp_t e;
    int   guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
      return;
    end
    e.err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    if (e.err)               begin e.lat = 1; e.n_re = 0; e.n_we = 0; end
    else if (!we)            begin e.lat = 3; e.n_re = 2; e.n_we = 0; end
    else if (size == 2'b10)  begin e.lat = 2; e.n_re = 0; e.n_we = 1; end
    else                     begin e.lat = 4; e.n_re = 2; e.n_we = 1; end
    e.rdata = (e.err || we) ? 32'd0 : exp_rdata;
    e.wdata = exp_wdata;
    e.addr  = addr;
    e.acc   = cyc + 1;
    sb.push_back(e);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int guard;
    for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    mem[0] <= 32'h1122_3344;
    mem[1] <= 32'h80FF_7F01;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_ram_we", {31'b0, ram_we}, 32'd0);
    check_eq("rst_ram_re", {31'b0, ram_re}, 32'd0);
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_ram_addr", ram_addr, 32'd0);
    rst = 1'b0;

    // Loads of every size and extension
    issue(1'b0, MEM_SIZE_W, 1'b0, 32'h0, 32'h0, 32'h1122_3344, 32'h0);
    issue(1'b0, MEM_SIZE_B, 1'b1, 32'h6, 32'h0, 32'hFFFF_FFFF, 32'h0);
    issue(1'b0, MEM_SIZE_B, 1'b0, 32'h7, 32'h0, 32'h0000_0080, 32'h0);
    issue(1'b0, MEM_SIZE_H, 1'b1, 32'h4, 32'h0, 32'h0000_7F01, 32'h0);
    issue(1'b0, MEM_SIZE_H, 1'b1, 32'h6, 32'h0, 32'hFFFF_80FF, 32'h0);
    issue(1'b0, MEM_SIZE_H, 1'b0, 32'h6, 32'h0, 32'h0000_80FF, 32'h0);

    // Word store, readback, then sub-word read-modify-writes
    issue(1'b1, MEM_SIZE_W, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);
    issue(1'b0, MEM_SIZE_W, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 32'h0);
    issue(1'b1, MEM_SIZE_B, 1'b0, 32'h9, 32'h1234_56AB, 32'h0, 32'hDEAD_ABEF);
    wait_done();
    check_eq("mem_after_byte_store", mem[2], 32'hDEAD_ABEF);
    issue(1'b1, MEM_SIZE_H, 1'b0, 32'hA, 32'h5555_CAFE, 32'h0, 32'hCAFE_ABEF);
    issue(1'b0, MEM_SIZE_W, 1'b0, 32'h8, 32'h0, 32'hCAFE_ABEF, 32'h0);
    issue(1'b0, MEM_SIZE_B, 1'b1, 32'hB, 32'h0, 32'hFFFF_FFCA, 32'h0);

    // Error paths: no RAM strobes, rdata forced to zero
    issue(1'b0, MEM_SIZE_H, 1'b0, 32'h3, 32'h0, 32'h0, 32'h0);
    issue(1'b0, 2'b11,      1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    issue(1'b1, MEM_SIZE_W, 1'b0, 32'h2, 32'h1, 32'h0, 32'h0);
    issue(1'b0, MEM_SIZE_W, 1'b0, 32'h1, 32'h0, 32'h0, 32'h0);
    wait_done();
    check_eq("mem0_after_errors", mem[0], 32'h1122_3344);

    // Reset during the write cycle of a byte store
    issue(1'b1, MEM_SIZE_B, 1'b0, 32'h0, 32'h0000_0077, 32'h0, 32'h1122_3377);
    guard = 0;
    while (!ram_we && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("reached_wr", {31'b0, ram_we}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("ready_after_rst", {31'b0, req_ready}, 32'd1);
    check_eq("resp_after_rst", {31'b0, resp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mem0_after_rst", mem[0], 32'h1122_3344);
    issue(1'b0, MEM_SIZE_W, 1'b0, 32'h0, 32'h0, 32'h1122_3344, 32'h0);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
